// File: rtl/glitch_reset_monitor.sv
// ---------------------------------------------------------------------------
// glitch_reset_monitor
//
// Target-side observer for the glitch reset path. After an arm request it
// watches the target reset pin and a target activity pin, measures how long
// reset was really held low and how long the target took to show a rising
// edge of activity after release. The glitch sequencer uses alive, boot_len
// and timeout to confirm the reset landed and to calibrate glitch offsets.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on tgt_rst_n / tgt_io (2 or more)
//   CNT_W        width of the pulse and boot measurement counters
//   TIMEOUT      cycles allowed in WAIT_ASSERT and in WAIT_BOOT
//
// Ports
//   clk_in     in   single clock domain
//   rst_n      in   asynchronous active-low reset
//   arm        in   start a measurement (accepted only in IDLE)
//   tgt_rst_n  in   target reset pin, asynchronous to clk_in
//   tgt_io     in   target activity pin, asynchronous to clk_in
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse, results valid and held until next arm
//   alive      out  activity edge seen after release
//   timeout    out  measurement ended by TIMEOUT
//   pulse_len  out  measured reset-low width in cycles
//   boot_len   out  release-to-activity delay in cycles
// ---------------------------------------------------------------------------
module glitch_reset_monitor #(
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      CNT_W       = 16,
    parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             tgt_rst_n,
    input  logic             tgt_io,
    output logic             busy,
    output logic             done,
    output logic             alive,
    output logic             timeout,
    output logic [CNT_W-1:0] pulse_len,
    output logic [CNT_W-1:0] boot_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ASSERT,
        S_IN_RESET,
        S_WAIT_BOOT,
        S_REPORT
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers. Both pins get the same depth so that measured
    // widths and delays are not skewed relative to each other.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_io_sync;
    logic                   r_io_q;
    logic                   w_rst_s;
    logic                   w_io_s;
    logic                   w_io_rise;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            // Reset to the inactive pin levels so leaving reset never looks
            // like a target reset or an activity edge.
            r_rst_sync <= '1;
            r_io_sync  <= '0;
            r_io_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value and the shift chain stays a chain.
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], tgt_rst_n};
            r_io_sync  <= {r_io_sync[SYNC_STAGES-2:0], tgt_io};
            r_io_q     <= r_io_sync[SYNC_STAGES-1];
        end
    end

    assign w_rst_s   = r_rst_sync[SYNC_STAGES-1];
    assign w_io_s    = r_io_sync[SYNC_STAGES-1];
    // Only an edge counts as activity; a level already high at release is
    // absorbed by r_io_q and never reported.
    assign w_io_rise = w_io_s & ~r_io_q;

    // -----------------------------------------------------------------------
    // Measurement FSM
    // -----------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt,  w_wait_nxt;
    logic [CNT_W-1:0] r_pulse_cnt, w_pulse_nxt;
    logic [CNT_W-1:0] r_boot_cnt,  w_boot_nxt;
    logic             r_alive,     w_alive_nxt;
    logic             r_timeout,   w_timeout_nxt;
    logic [CNT_W-1:0] r_pulse_len, w_pulse_len_nxt;
    logic [CNT_W-1:0] r_boot_len,  w_boot_len_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_busy,      w_busy_nxt;
    logic [CNT_W-1:0] w_wait_inc;

    assign w_wait_inc = r_wait_cnt + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_pulse_nxt     = r_pulse_cnt;
        w_boot_nxt      = r_boot_cnt;
        w_alive_nxt     = r_alive;
        w_timeout_nxt   = r_timeout;
        w_pulse_len_nxt = r_pulse_len;
        w_boot_len_nxt  = r_boot_len;

        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt     = S_WAIT_ASSERT;
                    w_wait_nxt      = '0;
                    w_pulse_nxt     = '0;
                    w_boot_nxt      = '0;
                    w_alive_nxt     = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_pulse_len_nxt = '0;
                    w_boot_len_nxt  = '0;
                end
            end

            S_WAIT_ASSERT: begin
                if (!w_rst_s) begin
                    // First low cycle counts as one cycle of reset.
                    w_state_nxt = S_IN_RESET;
                    w_pulse_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_wait_nxt = w_wait_inc;
                    if (w_wait_inc == TIMEOUT) begin
                        w_state_nxt     = S_REPORT;
                        w_timeout_nxt   = 1'b1;
                        w_pulse_len_nxt = '0;
                        w_boot_len_nxt  = '0;
                    end
                end
            end

            S_IN_RESET: begin
                if (!w_rst_s) begin
                    if (r_pulse_cnt != {CNT_W{1'b1}}) begin
                        w_pulse_nxt = r_pulse_cnt + 1'b1;
                    end
                end else begin
                    w_pulse_len_nxt = r_pulse_cnt;
                    if (w_io_rise) begin
                        // Activity in the very release cycle: zero boot delay.
                        w_state_nxt    = S_REPORT;
                        w_alive_nxt    = 1'b1;
                        w_boot_len_nxt = '0;
                    end else begin
                        w_state_nxt = S_WAIT_BOOT;
                        w_boot_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            S_WAIT_BOOT: begin
                // Re-reset wins over activity, and activity wins over the
                // timeout, so an edge on the last allowed cycle reports alive.
                if (!w_rst_s) begin
                    w_state_nxt = S_IN_RESET;
                    w_pulse_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                    w_boot_nxt  = '0;
                end else if (w_io_rise) begin
                    w_state_nxt    = S_REPORT;
                    w_alive_nxt    = 1'b1;
                    w_boot_len_nxt = r_boot_cnt;
                end else if (r_boot_cnt == TIMEOUT) begin
                    w_state_nxt    = S_REPORT;
                    w_timeout_nxt  = 1'b1;
                    w_boot_len_nxt = TIMEOUT;
                end else begin
                    w_boot_nxt = r_boot_cnt + 1'b1;
                end
            end

            S_REPORT: begin
                // arm is deliberately ignored here; a new run starts from IDLE.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Flags are computed from the next state so that done and busy are
        // registered yet line up exactly with the REPORT / non-IDLE states.
        w_done_nxt = (w_state_nxt == S_REPORT);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_boot_cnt  <= '0;
            r_alive     <= 1'b0;
            r_timeout   <= 1'b0;
            r_pulse_len <= '0;
            r_boot_len  <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_boot_cnt  <= w_boot_nxt;
            r_alive     <= w_alive_nxt;
            r_timeout   <= w_timeout_nxt;
            r_pulse_len <= w_pulse_len_nxt;
            r_boot_len  <= w_boot_len_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign alive     = r_alive;
    assign timeout   = r_timeout;
    assign pulse_len = r_pulse_len;
    assign boot_len  = r_boot_len;

endmodule

// File: tb/tb_glitch_reset_monitor.sv
// ---------------------------------------------------------------------------
// tb_glitch_reset_monitor
//
// Two monitor instances share clock and reset: index 0 uses TIMEOUT=50 for
// the timeout and boundary scenarios, index 1 keeps the default TIMEOUT for
// long boot delays. Expected results are queued when a scenario is started
// and compared when the instance pulses done.
// ---------------------------------------------------------------------------
module tb_glitch_reset_monitor;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic             alive;
        logic             timeout;
        logic [CNT_W-1:0] pulse_len;
        logic [CNT_W-1:0] boot_len;
    } exp_t;

    logic             clk_in;
    logic             rst_n;
    logic             arm       [2];
    logic             tgt_rst_n [2];
    logic             tgt_io    [2];
    logic             busy      [2];
    logic             done      [2];
    logic             alive     [2];
    logic             timeout   [2];
    logic [CNT_W-1:0] pulse_len [2];
    logic [CNT_W-1:0] boot_len  [2];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   done_cnt [2];
    int   done_cyc [2];
    exp_t q0 [$];
    exp_t q1 [$];

    glitch_reset_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .TIMEOUT     (16'd50)
    ) u_dut_short (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .arm       (arm[0]),
        .tgt_rst_n (tgt_rst_n[0]),
        .tgt_io    (tgt_io[0]),
        .busy      (busy[0]),
        .done      (done[0]),
        .alive     (alive[0]),
        .timeout   (timeout[0]),
        .pulse_len (pulse_len[0]),
        .boot_len  (boot_len[0])
    );

    glitch_reset_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) u_dut_long (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .arm       (arm[1]),
        .tgt_rst_n (tgt_rst_n[1]),
        .tgt_io    (tgt_io[1]),
        .busy      (busy[1]),
        .done      (done[1]),
        .alive     (alive[1]),
        .timeout   (timeout[1]),
        .pulse_len (pulse_len[1]),
        .boot_len  (boot_len[1])
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse is matched against the oldest
    // expectation queued for that instance.
    always @(negedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && done[i]) begin
                exp_t e;
                logic have;
                done_cnt[i]++;
                done_cyc[i] = cyc;
                have = 1'b0;
                e    = '0;
                if (i == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); have = 1'b1;
                end else if (i == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); have = 1'b1;
                end
                if (!have) begin
                    check($sformatf("i%0d_unexpected_done", i), 1, 0);
                end else begin
                    check($sformatf("i%0d_alive", i),     alive[i],     e.alive);
                    check($sformatf("i%0d_timeout", i),   timeout[i],   e.timeout);
                    check($sformatf("i%0d_pulse_len", i), pulse_len[i], e.pulse_len);
                    check($sformatf("i%0d_boot_len", i),  boot_len[i],  e.boot_len);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic a, input logic t,
                            input int pl, input int bl);
        exp_t e;
        e.alive     = a;
        e.timeout   = t;
        e.pulse_len = CNT_W'(pl);
        e.boot_len  = CNT_W'(bl);
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic do_arm(input int idx);
        arm[idx] = 1'b1;
        tick(1);
        arm[idx] = 1'b0;
        check($sformatf("i%0d_busy_after_arm", idx), busy[idx], 1);
    endtask

    task automatic pulse(input int idx, input int n);
        tgt_rst_n[idx] = 1'b0;
        tick(n);
        tgt_rst_n[idx] = 1'b1;
    endtask

    // Bounded wait for exactly one done pulse, then busy must have dropped.
    task automatic wait_done(input int idx, input int budget, input string tag);
        int start;
        int k;
        start = done_cnt[idx];
        k     = 0;
        while (done_cnt[idx] == start && k < budget) begin
            @(posedge clk_in);
            k++;
        end
        #1;
        check({tag, "_done_seen"}, done_cnt[idx] - start, 1);
        check({tag, "_busy_low"}, busy[idx], 0);
    endtask

    initial begin
        int arm_cyc;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            arm[i]       = 1'b0;
            tgt_rst_n[i] = 1'b1;
            tgt_io[i]    = 1'b0;
            done_cnt[i]  = 0;
            done_cyc[i]  = 0;
        end
        tick(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d_rst_busy", i),      busy[i],      0);
            check($sformatf("i%0d_rst_done", i),      done[i],      0);
            check($sformatf("i%0d_rst_alive", i),     alive[i],     0);
            check($sformatf("i%0d_rst_timeout", i),   timeout[i],   0);
            check($sformatf("i%0d_rst_pulse_len", i), pulse_len[i], 0);
            check($sformatf("i%0d_rst_boot_len", i),  boot_len[i],  0);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        tick(4);

        // Basic: 32-cycle pulse, activity 100 cycles after release.
        push_exp(1, 1'b1, 1'b0, 32, 100);
        do_arm(1);
        tick(2);
        pulse(1, 32);
        tick(100);
        tgt_io[1] = 1'b1;
        wait_done(1, 50, "basic");
        tick(3);
        check("basic_alive_held", alive[1], 1);
        check("basic_boot_held", boot_len[1], 100);
        tgt_io[1] = 1'b0;
        tick(4);

        // Activity edge in the very release cycle.
        push_exp(1, 1'b1, 1'b0, 5, 0);
        do_arm(1);
        tick(2);
        tgt_rst_n[1] = 1'b0;
        tick(5);
        tgt_rst_n[1] = 1'b1;
        tgt_io[1]    = 1'b1;
        wait_done(1, 50, "zero_boot");
        tgt_io[1] = 1'b0;
        tick(4);

        // No reset ever asserted: timeout with exact latency from arm.
        push_exp(0, 1'b0, 1'b1, 0, 0);
        arm_cyc = cyc;
        do_arm(0);
        wait_done(0, 100, "noreset");
        check("noreset_latency", done_cyc[0] - arm_cyc, 51);
        tick(4);

        // Dead target: io high throughout, so no edge is ever seen.
        tgt_io[0] = 1'b1;
        tick(4);
        push_exp(0, 1'b0, 1'b1, 32, 50);
        do_arm(0);
        tick(2);
        pulse(0, 32);
        wait_done(0, 200, "dead");
        tgt_io[0] = 1'b0;
        tick(4);

        // Boundary: edge exactly TIMEOUT cycles after release.
        push_exp(0, 1'b1, 1'b0, 8, 50);
        do_arm(0);
        tick(2);
        pulse(0, 8);
        tick(50);
        tgt_io[0] = 1'b1;
        wait_done(0, 50, "boundary");
        tgt_io[0] = 1'b0;
        tick(4);

        // Re-reset with a stray arm during the second pulse.
        push_exp(1, 1'b1, 1'b0, 20, 7);
        do_arm(1);
        tick(2);
        pulse(1, 10);
        tick(5);
        tgt_rst_n[1] = 1'b0;
        tick(10);
        arm[1] = 1'b1;
        tick(1);
        arm[1] = 1'b0;
        tick(9);
        tgt_rst_n[1] = 1'b1;
        tick(7);
        tgt_io[1] = 1'b1;
        wait_done(1, 50, "rereset");
        tgt_io[1] = 1'b0;
        tick(6);
        check("rereset_single_done", done_cnt[1], 3);

        // Async reset in the middle of a measurement: no done, outputs zero.
        do_arm(0);
        tick(2);
        tgt_rst_n[0] = 1'b0;
        tick(8);
        check("async_busy_before", busy[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy",      busy[0],      0);
        check("async_done",      done[0],      0);
        check("async_alive",     alive[0],     0);
        check("async_timeout",   timeout[0],   0);
        check("async_pulse_len", pulse_len[0], 0);
        check("async_boot_len",  boot_len[0],  0);
        tgt_rst_n[0] = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        tick(4);
        push_exp(0, 1'b1, 1'b0, 16, 3);
        do_arm(0);
        tick(2);
        pulse(0, 16);
        tick(3);
        tgt_io[0] = 1'b1;
        wait_done(0, 50, "after_async");
        tgt_io[0] = 1'b0;
        tick(4);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
